// File: rtl/pico_demo_ctrl.sv
// pico_demo_ctrl: clock-enable controller for a small demo processor.
// Synchronises the front-panel inputs, runs a HALT/RUN/STEP/FAST mode FSM,
// debounces the step button, and produces a one-cycle cpu_en pulse stream
// together with an LED latch and a pulse counter.
module pico_demo_ctrl #(
    parameter int CLK_HZ          = 50000000,
    parameter int STEP_HZ         = 10,
    parameter int DW              = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CW              = 16
) (
    input  logic          fastclk,
    input  logic          reset,
    input  logic [1:0]    mode,
    input  logic          step_btn,
    input  logic [DW-1:0] SW,
    input  logic [DW-1:0] cpu_outport,
    output logic          cpu_en,
    output logic [DW-1:0] sw_sync,
    output logic [DW-1:0] LED,
    output logic [CW-1:0] step_count
);

    localparam int DIV = CLK_HZ / STEP_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(DIV - 1);
    localparam logic [DBW-1:0] DB_MAX    = DBW'(DEBOUNCE_CYCLES - 1);

    // A step rate that leaves fewer than two clocks per step, or a zero-length
    // debounce window, cannot be built meaningfully.
    generate
        if (DIV < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
            $error("pico_demo_ctrl: CLK_HZ/STEP_HZ must be >= 2 and DEBOUNCE_CYCLES >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_FAST = 2'b11
    } state_t;

    // Map the synchronised mode code onto an FSM state.
    function automatic state_t mode_to_state(input logic [1:0] m);
        state_t s;
        case (m)
            2'b00:   s = ST_HALT;
            2'b01:   s = ST_RUN;
            2'b10:   s = ST_STEP;
            2'b11:   s = ST_FAST;
            default: s = ST_HALT;
        endcase
        return s;
    endfunction

    logic [1:0]    r_mode_s1, r_mode_s2;
    logic          r_btn_s1, r_btn_s2;
    logic [DW-1:0] r_sw_s1, r_sw_s2;
    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [DBW-1:0] r_db_cnt;
    logic          r_db_stable;
    logic          r_db_stable_d;
    logic          r_cpu_en;
    logic [DW-1:0] r_led;
    logic [CW-1:0] r_step_count;

    state_t        w_state_next;
    logic          w_state_chg;
    logic [PW-1:0] w_presc_next;
    logic          w_cpu_en_next;
    logic          w_db_rise;

    // Two-flop synchronisers for every asynchronous front-panel input.
    always_ff @(posedge fastclk or negedge reset) begin
        if (!reset) begin
            r_mode_s1 <= 2'b00;
            r_mode_s2 <= 2'b00;
            r_btn_s1  <= 1'b0;
            r_btn_s2  <= 1'b0;
            r_sw_s1   <= '0;
            r_sw_s2   <= '0;
        end else begin
            r_mode_s1 <= mode;
            r_mode_s2 <= r_mode_s1;
            r_btn_s1  <= step_btn;
            r_btn_s2  <= r_btn_s1;
            r_sw_s1   <= SW;
            r_sw_s2   <= r_sw_s1;
        end
    end

    // Debouncer: the stable level flips only after DEBOUNCE_CYCLES
    // consecutive cycles of disagreement; any agreement restarts the count.
    always_ff @(posedge fastclk or negedge reset) begin
        if (!reset) begin
            r_db_cnt      <= '0;
            r_db_stable   <= 1'b0;
            r_db_stable_d <= 1'b0;
        end else begin
            r_db_stable_d <= r_db_stable;
            if (r_btn_s2 == r_db_stable) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_MAX) begin
                r_db_stable <= ~r_db_stable;
                r_db_cnt    <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DBW'(1);
            end
        end
    end

    assign w_db_rise = r_db_stable & ~r_db_stable_d;

    // FSM state register and step prescaler.
    always_ff @(posedge fastclk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_HALT;
            r_presc <= '0;
        end else begin
            r_state <= w_state_next;
            r_presc <= w_presc_next;
        end
    end

    // Next state, prescaler and pulse decision. A state change wins over a
    // terminal count or a debounced press that lands in the same cycle.
    always_comb begin
        w_state_next  = mode_to_state(r_mode_s2);
        w_state_chg   = (w_state_next != r_state);
        w_presc_next  = '0;
        w_cpu_en_next = 1'b0;
        if (w_state_chg) begin
            w_presc_next  = '0;
            w_cpu_en_next = (w_state_next == ST_FAST);
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (r_presc == PRESC_MAX) begin
                        w_presc_next  = '0;
                        w_cpu_en_next = 1'b1;
                    end else begin
                        w_presc_next  = r_presc + PW'(1);
                        w_cpu_en_next = 1'b0;
                    end
                end
                ST_STEP: w_cpu_en_next = w_db_rise;
                ST_FAST: w_cpu_en_next = 1'b1;
                ST_HALT: w_cpu_en_next = 1'b0;
                default: w_cpu_en_next = 1'b0;
            endcase
        end
    end

    // Registered clock-enable, LED latch and wrapping pulse counter.
    always_ff @(posedge fastclk or negedge reset) begin
        if (!reset) begin
            r_cpu_en     <= 1'b0;
            r_led        <= '0;
            r_step_count <= '0;
        end else begin
            r_cpu_en <= w_cpu_en_next;
            if (r_cpu_en) begin
                r_led        <= cpu_outport;
                r_step_count <= r_step_count + CW'(1);
            end else begin
                r_led        <= r_led;
                r_step_count <= r_step_count;
            end
        end
    end

    assign cpu_en     = r_cpu_en;
    assign sw_sync    = r_sw_s2;
    assign LED        = r_led;
    assign step_count = r_step_count;

endmodule

// File: tb/tb_pico_demo_ctrl.sv
// Scoreboard bench for pico_demo_ctrl: the stimulus side feeds a timing-level
// reference model that predicts each cpu_en pulse; a monitor pops and
// compares whenever the DUT raises cpu_en.
module tb_pico_demo_ctrl;

    localparam int CLK_HZ = 100;
    localparam int STEP_HZ = 10;
    localparam int DEB = 4;
    localparam int DW = 8;
    localparam int CW = 4;
    localparam int DIV = CLK_HZ / STEP_HZ;

    logic          fastclk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    mode = 2'b00;
    logic          step_btn = 1'b0;
    logic [DW-1:0] SW = '0;
    logic [DW-1:0] cpu_outport = '0;
    logic          cpu_en;
    logic [DW-1:0] sw_sync;
    logic [DW-1:0] LED;
    logic [CW-1:0] step_count;

    pico_demo_ctrl #(
        .CLK_HZ(CLK_HZ), .STEP_HZ(STEP_HZ), .DW(DW),
        .DEBOUNCE_CYCLES(DEB), .CW(CW)
    ) dut (
        .fastclk(fastclk), .reset(reset), .mode(mode), .step_btn(step_btn),
        .SW(SW), .cpu_outport(cpu_outport), .cpu_en(cpu_en),
        .sw_sync(sw_sync), .LED(LED), .step_count(step_count)
    );

    always #5 fastclk = ~fastclk;

    int edge_n = 0;
    always @(posedge fastclk) edge_n <= edge_n + 1;

    typedef struct {
        int          cyc;
        logic [3:0]  cnt;
        logic [7:0]  led;
    } exp_t;

    exp_t exp_q[$];
    int   pulse_log[$];
    int   total = 0;
    int   bad = 0;

    // Reference model state: input histories, mode run-length, debounce
    // disagreement run, and the expected visible outputs.
    logic [1:0] hm1 = 2'b00, hm2 = 2'b00, s_old = 2'b00;
    logic       hb1 = 1'b0, hb2 = 1'b0, stable = 1'b0;
    logic       rise_pend = 1'b0, pulse_prev = 1'b0;
    int         diff = 0, run_len = 0;
    logic [7:0] hs1 = '0, m_sw = '0, m_led = '0;
    logic [3:0] m_cnt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, expv, edge_n);
        end
    endtask

    // Predict what the upcoming clock edge does, from the rules:
    // state follows raw mode two edges late; RUN pulses every DIV edges after
    // entry; FAST pulses every edge; STEP pulses one edge after the debounced
    // level rises (DEB consecutive disagreeing samples).
    task automatic model_edge();
        logic [1:0] s_new;
        logic       flip_rise;
        logic       p;
        exp_t       ne;
        if (!reset) begin
            hm1 = 2'b00; hm2 = 2'b00; s_old = 2'b00;
            hb1 = 1'b0; hb2 = 1'b0; stable = 1'b0;
            rise_pend = 1'b0; pulse_prev = 1'b0;
            diff = 0; run_len = 0;
            hs1 = '0; m_sw = '0; m_led = '0; m_cnt = '0;
        end else begin
            if (pulse_prev) begin
                m_cnt = m_cnt + 4'd1;
                m_led = cpu_outport;
            end
            m_sw = hs1;
            hs1 = SW;
            s_new = hm2;
            hm2 = hm1;
            hm1 = mode;
            flip_rise = 1'b0;
            if (hb2 != stable) begin
                diff++;
                if (diff >= DEB) begin
                    stable = ~stable;
                    diff = 0;
                    flip_rise = stable;
                end
            end else begin
                diff = 0;
            end
            hb2 = hb1;
            hb1 = step_btn;
            p = 1'b0;
            case (s_new)
                2'b11: p = 1'b1;
                2'b01: begin
                    run_len = (s_old == 2'b01) ? run_len + 1 : 0;
                    p = (run_len > 0) && (run_len % DIV == 0);
                end
                2'b10: p = (s_old == 2'b10) && rise_pend;
                default: p = 1'b0;
            endcase
            if (s_new != 2'b01) run_len = 0;
            rise_pend = flip_rise;
            s_old = s_new;
            pulse_prev = p;
            if (p) begin
                ne.cyc = edge_n + 1;
                ne.cnt = m_cnt;
                ne.led = m_led;
                exp_q.push_back(ne);
            end
        end
    endtask

    // Drive one cycle of inputs just after the falling edge, then predict.
    task automatic cycle(input logic [1:0] m, input logic b, input logic [7:0] op, input logic rst);
        @(negedge fastclk);
        #1;
        mode = m;
        step_btn = b;
        cpu_outport = op;
        SW = 8'($urandom);
        reset = rst;
        model_edge();
    endtask

    // Monitor: on every falling edge, match cpu_en pulses against the queue
    // and compare the other outputs with the model.
    always @(negedge fastclk) begin : monitor
        exp_t e;
        if (cpu_en) begin
            pulse_log.push_back(edge_n);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: cpu_en=1 at edge %0d, none expected", edge_n);
            end else begin
                e = exp_q.pop_front();
                check("pulse_edge", edge_n, e.cyc);
                check("pulse_step_count", 32'(step_count), 32'(e.cnt));
                check("pulse_led", 32'(LED), 32'(e.led));
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= edge_n) begin
            e = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL missing_pulse: cpu_en=0 at edge %0d, pulse expected at edge %0d", edge_n, e.cyc);
        end
        check("led", 32'(LED), 32'(m_led));
        check("step_count", 32'(step_count), 32'(m_cnt));
        check("sw_sync", 32'(sw_sync), 32'(m_sw));
    end

    initial begin : stim
        int p0, e0, rel, n, seg, bseg;
        logic [1:0] rm;
        logic rb;
        #1 reset = 1'b0;

        // Reset state
        for (int i = 0; i < 3; i++) cycle(2'b00, 1'b0, 8'($urandom), 1'b0);
        check("rst_cpu_en", 32'(cpu_en), 32'd0);
        check("rst_led", 32'(LED), 32'd0);
        check("rst_sw_sync", 32'(sw_sync), 32'd0);
        check("rst_step_count", 32'(step_count), 32'd0);
        for (int i = 0; i < 3; i++) cycle(2'b00, 1'b0, 8'($urandom), 1'b1);

        // RUN for 50 cycles
        p0 = pulse_log.size();
        for (int i = 0; i < 50; i++) cycle(2'b01, 1'b0, 8'($urandom), 1'b1);
        for (int i = 0; i < 5; i++) cycle(2'b00, 1'b0, 8'($urandom), 1'b1);
        n = pulse_log.size() - p0;
        check("run_pulse_count_4to6", 32'(n >= 4 && n <= 6), 32'd1);
        for (int i = p0 + 1; i < pulse_log.size(); i++)
            check("run_interval", pulse_log[i] - pulse_log[i-1], DIV);
        check("run_step_count", 32'(step_count), 32'(n % 16));
        check("halt_cpu_en", 32'(cpu_en), 32'd0);
        check("halt_presc", 32'(dut.r_presc), 32'd0);

        // STEP: clean press with LED capture, release, then a short glitch
        for (int i = 0; i < 5; i++) cycle(2'b10, 1'b0, 8'($urandom), 1'b1);
        p0 = pulse_log.size();
        cycle(2'b10, 1'b1, 8'hA5, 1'b1);
        e0 = edge_n + 1;
        for (int i = 0; i < 19; i++) cycle(2'b10, 1'b1, 8'hA5, 1'b1);
        check("step_one_pulse", pulse_log.size() - p0, 1);
        if (pulse_log.size() > p0)
            check("step_latency", pulse_log[p0] - (e0 - 1), DEB + 3);
        check("step_led_a5", 32'(LED), 32'hA5);
        for (int i = 0; i < 10; i++) cycle(2'b10, 1'b0, 8'h3C, 1'b1);
        check("release_led_hold", 32'(LED), 32'hA5);
        for (int i = 0; i < 3; i++) cycle(2'b10, 1'b1, 8'h3C, 1'b1);
        for (int i = 0; i < 10; i++) cycle(2'b10, 1'b0, 8'h3C, 1'b1);
        check("glitch_no_pulse", pulse_log.size() - p0, 1);
        check("glitch_led_hold", 32'(LED), 32'hA5);

        // FAST from a clean reset, then HALT
        for (int i = 0; i < 2; i++) cycle(2'b00, 1'b0, 8'($urandom), 1'b0);
        for (int i = 0; i < 3; i++) cycle(2'b00, 1'b0, 8'($urandom), 1'b1);
        for (int i = 0; i < 20; i++) cycle(2'b11, 1'b0, 8'($urandom), 1'b1);
        for (int i = 0; i < 5; i++) cycle(2'b00, 1'b0, 8'($urandom), 1'b1);
        check("fast_step_count_wrap", 32'(step_count), 32'd4);
        check("fast_halt_cpu_en", 32'(cpu_en), 32'd0);
        check("fast_halt_presc", 32'(dut.r_presc), 32'd0);

        // Reset in RUN with the prescaler at 7
        for (int i = 0; i < 40 && run_len != 7; i++) cycle(2'b01, 1'b0, 8'($urandom), 1'b1);
        @(posedge fastclk);
        #1;
        check("presc_at_7", 32'(dut.r_presc), 32'd7);
        cycle(2'b01, 1'b0, 8'($urandom), 1'b0);
        #1;
        check("midrst_cpu_en", 32'(cpu_en), 32'd0);
        check("midrst_led", 32'(LED), 32'd0);
        check("midrst_sw_sync", 32'(sw_sync), 32'd0);
        check("midrst_step_count", 32'(step_count), 32'd0);
        check("midrst_presc", 32'(dut.r_presc), 32'd0);
        cycle(2'b01, 1'b0, 8'($urandom), 1'b0);
        p0 = pulse_log.size();
        cycle(2'b01, 1'b0, 8'($urandom), 1'b1);
        rel = edge_n + 1;
        for (int i = 0; i < 20; i++) cycle(2'b01, 1'b0, 8'($urandom), 1'b1);
        check("midrst_pulse_seen", 32'(pulse_log.size() > p0), 32'd1);
        if (pulse_log.size() > p0)
            check("midrst_first_pulse_late", 32'(pulse_log[p0] >= rel + 11), 32'd1);

        // Reset in the middle of a debounce in STEP
        for (int i = 0; i < 5; i++) cycle(2'b10, 1'b0, 8'($urandom), 1'b1);
        p0 = pulse_log.size();
        for (int i = 0; i < 3; i++) cycle(2'b10, 1'b1, 8'($urandom), 1'b1);
        cycle(2'b10, 1'b1, 8'($urandom), 1'b0);
        cycle(2'b10, 1'b0, 8'($urandom), 1'b0);
        for (int i = 0; i < 15; i++) cycle(2'b10, 1'b0, 8'($urandom), 1'b1);
        check("debounce_rst_no_pulse", pulse_log.size() - p0, 0);

        // Randomised mode, button and reset activity
        seg = 0;
        bseg = 0;
        rm = 2'b00;
        rb = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (seg == 0) begin
                rm = 2'($urandom_range(0, 3));
                seg = $urandom_range(1, 30);
            end
            if (bseg == 0) begin
                rb = ~rb;
                bseg = $urandom_range(1, 9);
            end
            cycle(rm, rb, 8'($urandom), ($urandom_range(0, 149) != 0));
            seg--;
            bseg--;
        end
        for (int i = 0; i < 5; i++) cycle(2'b00, 1'b0, 8'($urandom), 1'b1);
        @(negedge fastclk);
        #1;
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
